// File: rtl/codificador_jogo.sv
// Game-word encoder: collects one 2-bit class per player into a packed word,
// then checks the lobo/medico counts and the absence of invalid codes.
module codificador_jogo #(
    parameter int N_JOGADORES = 5,
    parameter int N_LOBOS     = 1,
    parameter int N_MEDICOS   = 1
) (
    input  logic                       clock,
    input  logic                       reset,
    input  logic                       iniciar,
    input  logic                       escreve,
    input  logic [1:0]                 classe_in,
    output logic [2*N_JOGADORES-1:0]   jogo,
    output logic                       pronto,
    output logic                       erro,
    output logic [2:0]                 jogador_idx,
    output logic [2:0]                 db_estado
);

    localparam int W = 2 * N_JOGADORES;

    typedef enum logic [2:0] {
        OCIOSO   = 3'd0,
        RECEBE   = 3'd1,
        VERIFICA = 3'd2,
        PRONTO   = 3'd3,
        ERRO     = 3'd4
    } estado_t;

    estado_t      state_q;
    logic [W-1:0] jogo_q;
    logic         pronto_q;
    logic         erro_q;
    logic [2:0]   idx_q;
    logic [2:0]   lobos_q;
    logic [2:0]   medicos_q;
    logic         invalido_q;
    logic         estado_valido;

    assign estado_valido = (state_q == OCIOSO) || (state_q == RECEBE) ||
                           (state_q == VERIFICA) || (state_q == PRONTO) ||
                           (state_q == ERRO);

    // Handshake: escreve is a one-cycle strobe accepted only in RECEBE;
    // iniciar is a level that restarts from any valid state and wins over escreve.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q    <= OCIOSO;
            jogo_q     <= '0;
            pronto_q   <= 1'b0;
            erro_q     <= 1'b0;
            idx_q      <= 3'd0;
            lobos_q    <= 3'd0;
            medicos_q  <= 3'd0;
            invalido_q <= 1'b0;
        end else if (!estado_valido) begin
            state_q  <= OCIOSO;
            pronto_q <= 1'b0;
            erro_q   <= 1'b0;
        end else if (iniciar) begin
            state_q    <= RECEBE;
            jogo_q     <= '0;
            pronto_q   <= 1'b0;
            erro_q     <= 1'b0;
            idx_q      <= 3'd0;
            lobos_q    <= 3'd0;
            medicos_q  <= 3'd0;
            invalido_q <= 1'b0;
        end else begin
            case (state_q)
                RECEBE: begin
                    if (escreve) begin
                        // Player 0 lands in the MSBs of the word.
                        jogo_q[2*(N_JOGADORES-1-int'(idx_q)) +: 2] <= classe_in;
                        if (classe_in == 2'b01 && lobos_q != 3'd7)
                            lobos_q <= lobos_q + 3'd1;
                        if (classe_in == 2'b10 && medicos_q != 3'd7)
                            medicos_q <= medicos_q + 3'd1;
                        if (classe_in == 2'b11)
                            invalido_q <= 1'b1;
                        if (idx_q == 3'(N_JOGADORES - 1)) begin
                            idx_q   <= 3'd0;
                            state_q <= VERIFICA;
                        end else begin
                            idx_q <= idx_q + 3'd1;
                        end
                    end
                end
                VERIFICA: begin
                    if (lobos_q == 3'(N_LOBOS) && medicos_q == 3'(N_MEDICOS) && !invalido_q) begin
                        state_q  <= PRONTO;
                        pronto_q <= 1'b1;
                    end else begin
                        state_q <= ERRO;
                        erro_q  <= 1'b1;
                    end
                end
                default: begin
                    state_q <= state_q;
                end
            endcase
        end
    end

    assign jogo        = jogo_q;
    assign pronto      = pronto_q;
    assign erro        = erro_q;
    assign jogador_idx = idx_q;
    assign db_estado   = estado_valido ? state_q : 3'd7;

endmodule

// File: tb/tb_codificador_jogo.sv
// Directed and randomized bench for codificador_jogo against a counting
// reference model of the game rules.
module tb_codificador_jogo;

    localparam int N  = 5;
    localparam int NL = 1;
    localparam int NM = 1;
    localparam int W  = 2 * N;

    logic         clock = 1'b0;
    logic         reset;
    logic         iniciar;
    logic         escreve;
    logic [1:0]   classe_in;
    logic [W-1:0] jogo;
    logic         pronto;
    logic         erro;
    logic [2:0]   jogador_idx;
    logic [2:0]   db_estado;

    int n_checks = 0;
    int n_pass   = 0;
    int classes[N];

    codificador_jogo #(.N_JOGADORES(N), .N_LOBOS(NL), .N_MEDICOS(NM)) dut (
        .clock(clock), .reset(reset), .iniciar(iniciar), .escreve(escreve),
        .classe_in(classe_in), .jogo(jogo), .pronto(pronto), .erro(erro),
        .jogador_idx(jogador_idx), .db_estado(db_estado)
    );

    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1; tick(); reset = 1'b0;
    endtask

    task automatic start();
        iniciar = 1'b1; tick(); iniciar = 1'b0;
    endtask

    task automatic write(input logic [1:0] c, input int gap);
        escreve = 1'b1; classe_in = c; tick();
        escreve = 1'b0; classe_in = 2'($urandom_range(0, 3));
        for (int g = 0; g < gap; g++) tick();
    endtask

    function automatic logic [W-1:0] model_word();
        logic [W-1:0] w = '0;
        for (int p = 0; p < N; p++) w = (w << 2) | W'(classes[p]);
        return w;
    endfunction

    function automatic bit model_ok();
        int lobos = 0, medicos = 0, bad = 0;
        foreach (classes[p]) begin
            if (classes[p] == 1) lobos++;
            if (classes[p] == 2) medicos++;
            if (classes[p] == 3) bad++;
        end
        if (lobos > 7) lobos = 7;
        if (medicos > 7) medicos = 7;
        return (lobos == NL) && (medicos == NM) && (bad == 0);
    endfunction

    // Full game from classes[]: start, write all players, check verdict.
    task automatic play_game(input string tag, input int gap_max);
        bit ok;
        start();
        check({tag, "_start_db"}, db_estado, 1);
        for (int p = 0; p < N; p++) begin
            check({tag, "_idx"}, jogador_idx, p);
            write(2'(classes[p]), (p == N - 1) ? 0 : $urandom_range(0, gap_max));
        end
        check({tag, "_verifica_db"}, db_estado, 2);
        check({tag, "_verifica_flags"}, {pronto, erro}, 0);
        tick();
        ok = model_ok();
        check({tag, "_jogo"}, jogo, model_word());
        check({tag, "_pronto"}, pronto, ok);
        check({tag, "_erro"}, erro, !ok);
        check({tag, "_db"}, db_estado, ok ? 3 : 4);
        check({tag, "_idx_wrap"}, jogador_idx, 0);
    endtask

    initial begin
        reset = 1'b0; iniciar = 1'b0; escreve = 1'b0; classe_in = 2'b00;
        tick();
        do_reset();
        check("rst_jogo", jogo, 0);
        check("rst_flags", {pronto, erro}, 0);
        check("rst_idx", jogador_idx, 0);
        check("rst_db", db_estado, 0);

        // Writes while idle are ignored.
        write(2'b01, 1);
        check("idle_jogo", jogo, 0);
        check("idle_db", db_estado, 0);

        classes = '{1, 2, 0, 0, 0};
        play_game("g030", 3);
        check("g030_const", jogo, 10'b01_10_00_00_00);

        // Escreve in PRONTO is ignored.
        write(2'b01, 0);
        check("hold_jogo", jogo, 10'b01_10_00_00_00);
        check("hold_pronto", pronto, 1);
        start();
        check("restart_db", db_estado, 1);
        check("restart_jogo", jogo, 0);
        check("restart_pronto", pronto, 0);

        classes = '{0, 1, 0, 1, 2};
        play_game("g031", 2);
        check("g031_const", jogo, 10'b00_01_00_01_10);

        classes = '{2, 3, 1, 0, 0};
        play_game("g032", 2);
        check("g032_const", jogo, 10'b10_11_01_00_00);

        // Restart with simultaneous escreve drops the write.
        start();
        write(2'b01, 0); write(2'b10, 1); write(2'b11, 0);
        check("mid_idx", jogador_idx, 3);
        iniciar = 1'b1; escreve = 1'b1; classe_in = 2'b01; tick();
        iniciar = 1'b0; escreve = 1'b0;
        check("drop_jogo", jogo, 0);
        check("drop_idx", jogador_idx, 0);
        check("drop_db", db_estado, 1);
        classes = '{0, 0, 0, 2, 1};
        for (int p = 0; p < N; p++) write(2'(classes[p]), (p == N - 1) ? 0 : 1);
        tick();
        check("g033_pronto", pronto, 1);
        check("g033_jogo", jogo, 10'b00_00_00_10_01);

        // Reset in RECEBE.
        start();
        write(2'b10, 0); write(2'b01, 0);
        check("pre_rst_jogo", jogo, 10'b10_01_00_00_00);
        do_reset();
        check("rst2_jogo", jogo, 0);
        check("rst2_flags", {pronto, erro}, 0);
        check("rst2_idx", jogador_idx, 0);
        check("rst2_db", db_estado, 0);
        write(2'b01, 0);
        check("rst2_nochange_jogo", jogo, 0);
        check("rst2_nochange_idx", jogador_idx, 0);

        // iniciar during VERIFICA restarts instead of reporting.
        start();
        for (int p = 0; p < N; p++) write(2'b00, 0);
        check("ver_db", db_estado, 2);
        start();
        check("ver_restart_db", db_estado, 1);
        check("ver_restart_flags", {pronto, erro}, 0);

        // Randomized games; half forced to a valid mix.
        for (int t = 0; t < 40; t++) begin
            if (t % 2 == 0) begin
                int pl, pm;
                foreach (classes[p]) classes[p] = 0;
                pl = $urandom_range(0, N - 1);
                pm = (pl + $urandom_range(1, N - 1)) % N;
                classes[pl] = 1;
                classes[pm] = 2;
            end else begin
                foreach (classes[p]) classes[p] = $urandom_range(0, 3);
            end
            play_game("rnd", 3);
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/codificador_jogo.md
CODIFICADOR_JOGO -- requirements
Module: codificador_jogo

Interface
REQ-001 SHALL have parameter N_JOGADORES, default 5, meaning the number of players; packed word width W = 2*N_JOGADORES.
REQ-002 SHALL have parameter N_LOBOS, default 1, meaning the required count of class 01 (lobo).
REQ-003 SHALL have parameter N_MEDICOS, default 1, meaning the required count of class 10 (médico).
REQ-004 SHALL have port clock, input, 1, the single system clock; all logic on the rising edge.
REQ-005 SHALL have port reset, input, 1; reset is synchronous and active-high.
REQ-006 SHALL have port iniciar, input, 1, a level sampled each cycle that starts or restarts encoding.
REQ-007 SHALL have port escreve, input, 1, a write strobe; each high cycle is one class entry.
REQ-008 SHALL have port classe_in, input, 2, the class code: 00 aldeão, 01 lobo, 10 médico, 11 invalid.
REQ-009 SHALL have port jogo, output, W, the registered packed game word.
REQ-010 SHALL have port pronto, output, 1, high while a validated word is held.
REQ-011 SHALL have port erro, output, 1, high while a rejected word is held.
REQ-012 SHALL have port jogador_idx, output, 3, the index of the player the next escreve writes.
REQ-013 SHALL have port db_estado, output, 3, the current FSM state code.

Function
REQ-014 SHALL implement a Moore FSM with states OCIOSO=0, RECEBE=1, VERIFICA=2, PRONTO=3, ERRO=4; unused codes SHALL go to OCIOSO on the next cycle, with db_estado=7.
REQ-015 In OCIOSO, iniciar=1 SHALL clear jogo, jogador_idx, the lobo count, the médico count and the invalid flag, and SHALL go to RECEBE on the next edge.
REQ-016 In RECEBE, escreve=1 SHALL write classe_in into the slot for jogador_idx, update the counts and the invalid flag, and increment jogador_idx.
REQ-017 Player p SHALL occupy jogo[W-1-2p : W-2-2p], so player 0 is in the MSBs and player N_JOGADORES-1 is in bits [1:0].
REQ-018 In RECEBE, escreve=0 SHALL hold all state; gaps between writes of any length SHALL be allowed.
REQ-019 The write to jogador_idx = N_JOGADORES-1 SHALL move the FSM to VERIFICA; jogador_idx SHALL wrap to 0 and SHALL NOT exceed N_JOGADORES-1.
REQ-020 VERIFICA SHALL last exactly one cycle.
REQ-021 From VERIFICA, the FSM SHALL go to PRONTO when lobos==N_LOBOS, medicos==N_MEDICOS and no 11 was written; otherwise it SHALL go to ERRO.
REQ-022 Latency: the final escreve at edge k SHALL give VERIFICA after edge k and pronto or erro high after edge k+1.
REQ-023 The lobo and médico counts SHALL be 3 bits wide and SHALL saturate at 7.
REQ-024 pronto SHALL be 1 only in PRONTO; erro SHALL be 1 only in ERRO; they SHALL never be high together.
REQ-025 In PRONTO and ERRO, jogo SHALL hold the written word unchanged until iniciar=1, which SHALL act as in REQ-015.
REQ-026 iniciar=1 in RECEBE or VERIFICA SHALL restart per REQ-015, and iniciar SHALL take priority over a simultaneous escreve, whose write is dropped.
REQ-027 escreve SHALL be ignored in OCIOSO, VERIFICA, PRONTO and ERRO.

Reset
REQ-028 reset=1 at a clock edge SHALL force OCIOSO and set jogo=0, pronto=0, erro=0, jogador_idx=0, db_estado=0 and clear the counts and the invalid flag, from any state, and SHALL take priority over iniciar and escreve.
REQ-029 After reset is released, no output SHALL change until iniciar=1.

Verification
REQ-030 Bench: reset, iniciar, then writes 01,10,00,00,00 with gaps -> jogo=10'b01_10_00_00_00, pronto=1 two edges after the last write, erro=0, db_estado=3.
REQ-031 Bench: writes 00,01,00,01,10 -> erro=1, pronto=0, jogo=10'b00_01_00_01_10, db_estado=4.
REQ-032 Bench: writes 10,11,01,00,00 -> erro=1 (invalid code), jogo=10'b10_11_01_00_00.
REQ-033 Bench: 3 writes, then iniciar together with escreve -> jogo=0, jogador_idx=0, write dropped; 5 fresh writes 00,00,00,10,01 -> pronto=1, jogo=10'b00_00_00_10_01.
REQ-034 Bench: reset asserted in RECEBE after 2 writes -> next edge all outputs 0 and db_estado=0; escreve without iniciar -> no change.
REQ-035 Bench: in PRONTO, pulse escreve with 01 -> jogo and pronto unchanged; then iniciar -> RECEBE with jogo=0.
